skew_feeder: RTL and testbench



---
 rtl/skew_feeder_pkg.sv | 15 +
 rtl/skew_feeder_if.sv | 26 ++
 rtl/skew_feeder_matrix_regfile.sv | 36 +++
 rtl/skew_feeder.sv | 173 +++++++++++++++++
 tb/tb_skew_feeder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/skew_feeder_pkg.sv
// Shared types and sizing helpers for the skew feeder.
package skew_feeder_pkg;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, FEED, DONE} skew_state_e;

  // Number of skew steps needed to stream every operand through the array edge.
  function automatic int skew_steps(input int h, input int w, input int k);
    return k + ((h > w) ? h : w) - 1;
  endfunction

  function automatic int cnt_w(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// Byte-entry stream plus skewed row/column operand bus of the skew feeder.
interface skew_feeder_if #(
  parameter int width_p        = 8,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2
);
  logic                              valid_i;
  logic [width_p-1:0]                data_i;
  logic                              ready_o;
  logic                              ready_i;
  logic [array_height_p-1:0]         row_valid_o;
  logic [array_height_p*width_p-1:0] row_data_o;
  logic [array_width_p-1:0]          col_valid_o;
  logic [array_width_p*width_p-1:0]  col_data_o;
  logic                              done_o;

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, row_valid_o, row_data_o, col_valid_o, col_data_o, done_o
  );

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, row_valid_o, row_data_o, col_valid_o, col_data_o, done_o
  );
endinterface

// File: rtl/skew_feeder_matrix_regfile.sv
// Operand matrix store: row-major write port, one combinational read port per lane.
module matrix_regfile #(
  parameter int rows_p   = 2,
  parameter int cols_p   = 2,
  parameter int width_p  = 8,
  parameter int lanes_p  = 2,
  parameter int addr_w_p = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              we_i,
  input  logic [addr_w_p-1:0]               waddr_i,
  input  logic [width_p-1:0]                wdata_i,
  input  logic [lanes_p-1:0][addr_w_p-1:0]  raddr_i,
  output logic [lanes_p-1:0][width_p-1:0]   rdata_o
);

  localparam int depth_lp = rows_p * cols_p;

  logic [depth_lp-1:0][width_p-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) mem_q <= '0;
    else            mem_q <= mem_d;
  end

  always_comb begin
    for (int l = 0; l < lanes_p; l++) rdata_o[l] = mem_q[raddr_i[l]];
  end

endmodule

// File: rtl/skew_feeder.sv
// Loads A then B from a byte stream and replays them as diagonally skewed row/column streams.
// Optional SKEW_FEEDER_REPLAY_EN adds replay_i to re-feed the stored matrices without reloading.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int k_p            = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        flush_i,
  skew_feeder_if.slave fd
`ifdef SKEW_FEEDER_REPLAY_EN
  , input logic       replay_i
`endif
);

  localparam int H      = array_height_p;
  localparam int W      = array_width_p;
  localparam int K      = k_p;
  localparam int T      = skew_steps(H, W, K);
  localparam int A_N    = H * K;
  localparam int B_N    = K * W;
  localparam int IDX_W  = cnt_w(((A_N > B_N) ? A_N : B_N) - 1);
  localparam int STEP_W = cnt_w(T - 1);
  localparam int A_AW   = cnt_w(A_N - 1);
  localparam int B_AW   = cnt_w(B_N - 1);

  skew_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [STEP_W-1:0] t_q, t_d;
  logic              done_q, done_d;

  logic replay_go, ready, take;

`ifdef SKEW_FEEDER_REPLAY_EN
  assign replay_go = (state_q == LOAD_A) && (idx_q == '0) && replay_i && !flush_i;
`else
  assign replay_go = 1'b0;
`endif

  assign ready = ((state_q == LOAD_A) || (state_q == LOAD_B)) && !replay_go;
  // A flushed cycle never commits its byte, even though ready_o is high.
  assign take  = fd.valid_i && ready && !flush_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    t_d     = t_q;
    done_d  = 1'b0;
    if (flush_i) begin
      state_d = LOAD_A;
      idx_d   = '0;
      t_d     = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (replay_go) begin
            state_d = FEED;
            t_d     = '0;
          end else if (take) begin
            if (idx_q == IDX_W'(A_N - 1)) begin
              state_d = LOAD_B;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (take) begin
            if (idx_q == IDX_W'(B_N - 1)) begin
              state_d = FEED;
              idx_d   = '0;
              t_d     = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        FEED: begin
          if (fd.ready_i) begin
            if (t_q == STEP_W'(T - 1)) begin
              state_d = DONE;
              t_d     = '0;
              done_d  = 1'b1;
            end else begin
              t_d = t_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = LOAD_A;
          idx_d   = '0;
          t_d     = '0;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
      done_q  <= done_d;
    end
  end

  logic [H-1:0][A_AW-1:0]    a_raddr;
  logic [H-1:0][width_p-1:0] a_rdata;
  logic [W-1:0][B_AW-1:0]    b_raddr;
  logic [W-1:0][width_p-1:0] b_rdata;
  logic [H-1:0]              row_vld;
  logic [W-1:0]              col_vld;
  logic [H*width_p-1:0]      row_dat;
  logic [W*width_p-1:0]      col_dat;

  matrix_regfile #(.rows_p(H), .cols_p(K), .width_p(width_p), .lanes_p(H), .addr_w_p(A_AW)) u_a (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .we_i(take && (state_q == LOAD_A)), .waddr_i(A_AW'(idx_q)), .wdata_i(fd.data_i),
    .raddr_i(a_raddr), .rdata_o(a_rdata)
  );

  matrix_regfile #(.rows_p(K), .cols_p(W), .width_p(width_p), .lanes_p(W), .addr_w_p(B_AW)) u_b (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .we_i(take && (state_q == LOAD_B)), .waddr_i(B_AW'(idx_q)), .wdata_i(fd.data_i),
    .raddr_i(b_raddr), .rdata_o(b_rdata)
  );

  // Row r sees A[r][t-r], column c sees B[t-c][c], while that offset is inside 0..K-1.
  always_comb begin
    row_vld = '0;
    col_vld = '0;
    a_raddr = '0;
    b_raddr = '0;
    for (int r = 0; r < H; r++) begin
      if ((state_q == FEED) && (int'(t_q) >= r) && (int'(t_q) - r < K)) begin
        row_vld[r] = 1'b1;
        a_raddr[r] = A_AW'(r * K + int'(t_q) - r);
      end
    end
    for (int c = 0; c < W; c++) begin
      if ((state_q == FEED) && (int'(t_q) >= c) && (int'(t_q) - c < K)) begin
        col_vld[c] = 1'b1;
        b_raddr[c] = B_AW'((int'(t_q) - c) * W + c);
      end
    end
  end

  always_comb begin
    row_dat = '0;
    col_dat = '0;
    for (int r = 0; r < H; r++) if (row_vld[r]) row_dat[r*width_p +: width_p] = a_rdata[r];
    for (int c = 0; c < W; c++) if (col_vld[c]) col_dat[c*width_p +: width_p] = b_rdata[c];
  end

  assign fd.ready_o     = ready;
  assign fd.row_valid_o = row_vld;
  assign fd.row_data_o  = row_dat;
  assign fd.col_valid_o = col_vld;
  assign fd.col_data_o  = col_dat;
  assign fd.done_o      = done_q;

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: table-driven skew vectors plus a model-fed scoreboard of expected steps.
module tb_skew_feeder;
  import skew_feeder_pkg::*;

  localparam int WP = 8;
  localparam int H  = 2;
  localparam int W  = 2;
  localparam int K  = 2;
  localparam int T  = skew_steps(H, W, K);
  localparam int NB = H * K + K * W;

  typedef struct packed {
    logic [H-1:0]    rv;
    logic [H*WP-1:0] rd;
    logic [W-1:0]    cv;
    logic [W*WP-1:0] cd;
  } step_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
`ifdef SKEW_FEEDER_REPLAY_EN
  logic replay = 1'b0;
`endif

  skew_feeder_if #(.width_p(WP), .array_width_p(W), .array_height_p(H)) bus ();

  skew_feeder #(.width_p(WP), .array_width_p(W), .array_height_p(H), .k_p(K)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush), .fd(bus)
`ifdef SKEW_FEEDER_REPLAY_EN
    , .replay_i(replay)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  step_t       exp_q[$];
  step_t       tbl[T];
  logic [WP-1:0] ld[NB];
  logic [WP-1:0] a_m[H][K];
  logic [WP-1:0] b_m[K][W];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic step_t cur();
    step_t s;
    s.rv = bus.row_valid_o;
    s.rd = bus.row_data_o;
    s.cv = bus.col_valid_o;
    s.cd = bus.col_data_o;
    return s;
  endfunction

  task automatic push_model();
    for (int t = 0; t < T; t++) begin
      step_t s;
      s = '0;
      for (int r = 0; r < H; r++)
        if (t - r >= 0 && t - r < K) begin
          s.rv[r] = 1'b1;
          s.rd[r*WP +: WP] = a_m[r][t-r];
        end
      for (int c = 0; c < W; c++)
        if (t - c >= 0 && t - c < K) begin
          s.cv[c] = 1'b1;
          s.cd[c*WP +: WP] = b_m[t-c][c];
        end
      exp_q.push_back(s);
    end
  endtask

  task automatic drive_byte(input logic [WP-1:0] b, input int i);
    bus.valid_i = 1'b1;
    bus.data_i  = b;
    @(negedge clk);
    chk("ready_o during load", bus.ready_o, 1);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    if (i < H * K) a_m[i / K][i % K] = b;
    else           b_m[(i - H * K) / W][(i - H * K) % W] = b;
  endtask

  task automatic load_all(input bit toggle);
    for (int i = 0; i < NB; i++) begin
      drive_byte(ld[i], i);
      if (toggle && i < NB - 1) begin
        bus.valid_i = 1'b0;
        bus.data_i  = 8'hEE;
        @(negedge clk);
        chk("ready_o in idle gap", bus.ready_o, 1);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic fill_seq();
    for (int i = 0; i < NB; i++) ld[i] = WP'(i + 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NB; i++) ld[i] = WP'($urandom_range(1, 255));
  endtask

  // Entered at posedge+1 with the DUT in FEED t=0; leaves at posedge+1 back in LOAD_A.
  task automatic run_feed(input int stall_at, input int stall_n, input string tag);
    int step = 0, stalled = 0, cycles = 0;
    bit seen_done = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      bus.ready_i = !(step == stall_at && stalled < stall_n);
      @(negedge clk);
      if (bus.done_o) begin
        seen_done = 1'b1;
        chk({tag, " valids in DONE"}, {bus.row_valid_o, bus.col_valid_o}, 0);
      end else begin
        cycles++;
        chk({tag, " ready_o in FEED"}, bus.ready_o, 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s extra step: got %0h, expected none", tag, cur());
        end else begin
          chk($sformatf("%s step %0d", tag, step), cur(), exp_q[0]);
          if (bus.ready_i) begin
            void'(exp_q.pop_front());
            step++;
          end else begin
            stalled++;
          end
        end
      end
      @(posedge clk); #1;
    end
    chk({tag, " done seen"}, seen_done, 1);
    chk({tag, " feed cycles"}, cycles, T + stall_n);
    chk({tag, " queue drained"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk({tag, " done single pulse"}, bus.done_o, 0);
    chk({tag, " ready_o after done"}, bus.ready_o, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{rv: 2'b01, rd: {8'd0, 8'd1}, cv: 2'b01, cd: {8'd0, 8'd5}};
    tbl[1] = '{rv: 2'b11, rd: {8'd3, 8'd2}, cv: 2'b11, cd: {8'd6, 8'd7}};
    tbl[2] = '{rv: 2'b10, rd: {8'd4, 8'd0}, cv: 2'b10, cd: {8'd8, 8'd0}};

    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #12;
    chk("reset ready_o", bus.ready_o, 1);
    chk("reset outputs", cur(), 0);
    chk("reset done_o", bus.done_o, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference load A=[1 2;3 4], B=[5 6;7 8] against the fixed vector table.
    fill_seq();
    load_all(1'b0);
    for (int t = 0; t < T; t++) exp_q.push_back(tbl[t]);
    run_feed(-1, 0, "table");

    // Same load, three stalled cycles at t1.
    load_all(1'b0);
    for (int t = 0; t < T; t++) exp_q.push_back(tbl[t]);
    run_feed(1, 3, "stall");

    // Flush after five bytes, with a byte presented in the flush cycle.
    fill_rand();
    for (int i = 0; i < 5; i++) drive_byte(ld[i], i);
    bus.valid_i = 1'b1;
    bus.data_i  = 8'hAA;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("flush ready_o", bus.ready_o, 1);
    chk("flush done_o", bus.done_o, 0);
    @(posedge clk); #1;
    fill_rand();
    load_all(1'b0);
    push_model();
    run_feed(-1, 0, "post-flush");

    // Asynchronous reset while t1 is on the outputs.
    fill_rand();
    load_all(1'b0);
    push_model();
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("pre-reset t0", cur(), exp_q[0]);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    @(negedge clk);
    chk("pre-reset t1", cur(), exp_q[0]);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", cur(), 0);
    chk("async reset ready_o", bus.ready_o, 1);
    chk("async reset done_o", bus.done_o, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-reset done_o", bus.done_o, 0);
      chk("post-reset ready_o", bus.ready_o, 1);
    end
    @(posedge clk); #1;

    // valid_i toggling during load.
    fill_rand();
    load_all(1'b1);
    push_model();
    run_feed(-1, 0, "toggle");

`ifdef SKEW_FEEDER_REPLAY_EN
    replay = 1'b1;
    @(negedge clk);
    chk("replay ready_o", bus.ready_o, 0);
    @(posedge clk); #1;
    replay = 1'b0;
    push_model();
    run_feed(-1, 0, "replay");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
